// File: rtl/pcie_us_cfg_mgmt_arb.sv
// pcie_us_cfg_mgmt_arb
//   Round-robin arbiter placing PORTS requesters onto the single cfg_mgmt
//   port of the UltraScale PCIe IP core. The grant is held for one complete
//   read/write transaction. Completion (done pulse plus read data) is
//   registered and routed back to the granted port only.
//
//   Optional feature (macro PCIE_CFG_MGMT_TIMEOUT_EN): abort a transaction
//   that gets no cfg_mgmt_read_write_done within TIMEOUT+1 active cycles.
//   The aborted transaction returns 32'hFFFFFFFF and pulses timeout_error.
//   Without the macro, timeout_error is tied low and no counter exists.
//
// Ports
//   clk, rst                      clock, synchronous active-high reset
//   s_cfg_mgmt_*                  per-port requester side, port i in slice i
//   s_cfg_mgmt_read_data          shared read data, valid with done pulse
//   s_cfg_mgmt_read_write_done    one-cycle done pulse per port
//   cfg_mgmt_*                    IP core side
//   timeout_error                 one-cycle pulse on an aborted transaction
module pcie_us_cfg_mgmt_arb #(
  parameter int PORTS   = 2,
  parameter int TIMEOUT = 1023
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PORTS*10-1:0] s_cfg_mgmt_addr,
  input  logic [PORTS*8-1:0]  s_cfg_mgmt_function_number,
  input  logic [PORTS-1:0]    s_cfg_mgmt_write,
  input  logic [PORTS*32-1:0] s_cfg_mgmt_write_data,
  input  logic [PORTS*4-1:0]  s_cfg_mgmt_byte_enable,
  input  logic [PORTS-1:0]    s_cfg_mgmt_read,
  output logic [31:0]         s_cfg_mgmt_read_data,
  output logic [PORTS-1:0]    s_cfg_mgmt_read_write_done,
  output logic [9:0]          cfg_mgmt_addr,
  output logic [7:0]          cfg_mgmt_function_number,
  output logic                cfg_mgmt_write,
  output logic [31:0]         cfg_mgmt_write_data,
  output logic [3:0]          cfg_mgmt_byte_enable,
  output logic                cfg_mgmt_read,
  input  logic [31:0]         cfg_mgmt_read_data,
  input  logic                cfg_mgmt_read_write_done,
  output logic                timeout_error
);

  localparam int GW = (PORTS > 1) ? $clog2(PORTS) : 1;

  if (PORTS < 1 || PORTS > 16 || TIMEOUT < 0) begin : g_bad_param
    $error("pcie_us_cfg_mgmt_arb: PORTS must be 1..16 and TIMEOUT >= 0");
  end

  typedef enum logic [1:0] {
    IDLE,
    ACTIVE,
    DONE
  } state_t;

  state_t            state, state_n;
  logic [PORTS-1:0]  req;
  logic [GW-1:0]     last_grant, last_grant_n;
  logic [GW-1:0]     grant, grant_n;
  logic [GW-1:0]     sel, cand;
  logic              sel_valid;

  logic [9:0]        addr_n;
  logic [7:0]        fn_n;
  logic              wr_n, rd_n;
  logic [31:0]       wdata_n;
  logic [3:0]        be_n;
  logic [31:0]       rdata_n;
  logic [PORTS-1:0]  done_n;

`ifdef PCIE_CFG_MGMT_TIMEOUT_EN
  localparam int TW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  logic [TW-1:0]     tmo_cnt, tmo_cnt_n;
  logic              tmo_err_n;
`else
  assign timeout_error = 1'b0;
`endif

  // Search starts one past the last granted port, so the port just served
  // has the lowest priority on the next arbitration.
  always_comb begin
    req       = s_cfg_mgmt_read | s_cfg_mgmt_write;
    sel       = '0;
    sel_valid = 1'b0;
    cand      = '0;
    for (int unsigned i = 1; i <= PORTS; i++) begin
      cand = GW'((32'(last_grant) + i) % PORTS);
      if (!sel_valid && req[cand]) begin
        sel       = cand;
        sel_valid = 1'b1;
      end
    end
  end

  always_comb begin
    state_n      = state;
    grant_n      = grant;
    last_grant_n = last_grant;
    addr_n       = cfg_mgmt_addr;
    fn_n         = cfg_mgmt_function_number;
    wr_n         = cfg_mgmt_write;
    rd_n         = cfg_mgmt_read;
    wdata_n      = cfg_mgmt_write_data;
    be_n         = cfg_mgmt_byte_enable;
    rdata_n      = s_cfg_mgmt_read_data;
    done_n       = '0;
`ifdef PCIE_CFG_MGMT_TIMEOUT_EN
    tmo_cnt_n    = tmo_cnt;
    tmo_err_n    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (sel_valid) begin
          grant_n = sel;
          addr_n  = s_cfg_mgmt_addr[32'(sel)*10 +: 10];
          fn_n    = s_cfg_mgmt_function_number[32'(sel)*8 +: 8];
          wdata_n = s_cfg_mgmt_write_data[32'(sel)*32 +: 32];
          be_n    = s_cfg_mgmt_byte_enable[32'(sel)*4 +: 4];
          // Simultaneous read and write on one port forwards only the write.
          wr_n    = s_cfg_mgmt_write[sel];
          rd_n    = s_cfg_mgmt_read[sel] & ~s_cfg_mgmt_write[sel];
          state_n = ACTIVE;
`ifdef PCIE_CFG_MGMT_TIMEOUT_EN
          tmo_cnt_n = TW'(TIMEOUT);
`endif
        end
      end
      ACTIVE: begin
        // Done takes precedence over an expiry in the same cycle.
        if (cfg_mgmt_read_write_done) begin
          rd_n          = 1'b0;
          wr_n          = 1'b0;
          rdata_n       = cfg_mgmt_read_data;
          done_n[grant] = 1'b1;
          last_grant_n  = grant;
          state_n       = DONE;
        end
`ifdef PCIE_CFG_MGMT_TIMEOUT_EN
        else if (tmo_cnt == '0) begin
          rd_n          = 1'b0;
          wr_n          = 1'b0;
          rdata_n       = '1;
          done_n[grant] = 1'b1;
          tmo_err_n     = 1'b1;
          last_grant_n  = grant;
          state_n       = DONE;
        end else begin
          tmo_cnt_n = tmo_cnt - 1'b1;
        end
`endif
      end
      DONE: begin
        // Turnaround cycle: the requester drops its request after seeing done.
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state                      <= IDLE;
      grant                      <= '0;
      last_grant                 <= GW'(PORTS - 1);
      cfg_mgmt_addr              <= '0;
      cfg_mgmt_function_number   <= '0;
      cfg_mgmt_write             <= 1'b0;
      cfg_mgmt_read              <= 1'b0;
      cfg_mgmt_write_data        <= '0;
      cfg_mgmt_byte_enable       <= '0;
      s_cfg_mgmt_read_data       <= '0;
      s_cfg_mgmt_read_write_done <= '0;
`ifdef PCIE_CFG_MGMT_TIMEOUT_EN
      tmo_cnt                    <= '0;
      timeout_error              <= 1'b0;
`endif
    end else begin
      state                      <= state_n;
      grant                      <= grant_n;
      last_grant                 <= last_grant_n;
      cfg_mgmt_addr              <= addr_n;
      cfg_mgmt_function_number   <= fn_n;
      cfg_mgmt_write             <= wr_n;
      cfg_mgmt_read              <= rd_n;
      cfg_mgmt_write_data        <= wdata_n;
      cfg_mgmt_byte_enable       <= be_n;
      s_cfg_mgmt_read_data       <= rdata_n;
      s_cfg_mgmt_read_write_done <= done_n;
`ifdef PCIE_CFG_MGMT_TIMEOUT_EN
      tmo_cnt                    <= tmo_cnt_n;
      timeout_error              <= tmo_err_n;
`endif
    end
  end

endmodule

// File: tb/tb_pcie_us_cfg_mgmt_arb.sv
// Directed self-checking bench for pcie_us_cfg_mgmt_arb with PORTS=2.
// Inputs are driven and outputs sampled 1 time unit after each rising edge.
module tb_pcie_us_cfg_mgmt_arb;

  localparam int P = 2;
`ifdef PCIE_CFG_MGMT_TIMEOUT_EN
  localparam int TMO = 15;
`else
  localparam int TMO = 1023;
`endif

  logic            clk = 1'b0;
  logic            rst;
  logic [P*10-1:0] s_addr;
  logic [P*8-1:0]  s_fn;
  logic [P-1:0]    s_write;
  logic [P*32-1:0] s_wdata;
  logic [P*4-1:0]  s_be;
  logic [P-1:0]    s_read;
  logic [31:0]     s_rdata;
  logic [P-1:0]    s_done;
  logic [9:0]      c_addr;
  logic [7:0]      c_fn;
  logic            c_write;
  logic [31:0]     c_wdata;
  logic [3:0]      c_be;
  logic            c_read;
  logic [31:0]     c_rdata;
  logic            c_done;
  logic            terr;

  int n_cmp = 0;
  int n_err = 0;

  pcie_us_cfg_mgmt_arb #(.PORTS(P), .TIMEOUT(TMO)) dut (
    .clk                        (clk),
    .rst                        (rst),
    .s_cfg_mgmt_addr            (s_addr),
    .s_cfg_mgmt_function_number (s_fn),
    .s_cfg_mgmt_write           (s_write),
    .s_cfg_mgmt_write_data      (s_wdata),
    .s_cfg_mgmt_byte_enable     (s_be),
    .s_cfg_mgmt_read            (s_read),
    .s_cfg_mgmt_read_data       (s_rdata),
    .s_cfg_mgmt_read_write_done (s_done),
    .cfg_mgmt_addr              (c_addr),
    .cfg_mgmt_function_number   (c_fn),
    .cfg_mgmt_write             (c_write),
    .cfg_mgmt_write_data        (c_wdata),
    .cfg_mgmt_byte_enable       (c_be),
    .cfg_mgmt_read              (c_read),
    .cfg_mgmt_read_data         (c_rdata),
    .cfg_mgmt_read_write_done   (c_done),
    .timeout_error              (terr)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    step();
    step();
    n_cmp++; if ({c_addr, c_fn, c_write, c_wdata, c_be, c_read} !== '0) begin n_err++; $display("FAIL reset_cfg: got %h want 0", {c_addr, c_fn, c_write, c_wdata, c_be, c_read}); end
    n_cmp++; if ({s_rdata, s_done, terr} !== '0) begin n_err++; $display("FAIL reset_s: got %h want 0", {s_rdata, s_done, terr}); end
    rst = 1'b0;
    step();
    n_cmp++; if ({c_read, c_write, s_done} !== '0) begin n_err++; $display("FAIL reset_idle: got %b want 0", {c_read, c_write, s_done}); end
  endtask

  // Port 0 reads 0x032; core answers in cycle 6 -> done pulse in cycle 7.
  task automatic test_single_read();
    s_addr[9:0] = 10'h032;
    s_fn[7:0]   = 8'h00;
    s_read[0]   = 1'b1;
    step();
    for (int c = 1; c <= 6; c++) begin
      n_cmp++; if ({c_read, c_write, c_addr, c_fn} !== {1'b1, 1'b0, 10'h032, 8'h00}) begin n_err++; $display("FAIL sr_active_c%0d: got r%b w%b a%h f%h want r1 w0 a032 f00", c, c_read, c_write, c_addr, c_fn); end
      n_cmp++; if (s_done !== 2'b00) begin n_err++; $display("FAIL sr_nodone_c%0d: got %b want 00", c, s_done); end
      if (c == 6) begin
        c_done  = 1'b1;
        c_rdata = 32'h0000_2810;
      end
      step();
    end
    c_done  = 1'b0;
    c_rdata = 32'hBAD0_BAD0;
    n_cmp++; if (s_done !== 2'b01) begin n_err++; $display("FAIL sr_done: got %b want 01", s_done); end
    n_cmp++; if (s_rdata !== 32'h0000_2810) begin n_err++; $display("FAIL sr_rdata: got %h want 00002810", s_rdata); end
    n_cmp++; if (c_read !== 1'b0) begin n_err++; $display("FAIL sr_drop: got %b want 0", c_read); end
    s_read[0] = 1'b0;
    step();
    n_cmp++; if (s_done !== 2'b00) begin n_err++; $display("FAIL sr_done_pulse: got %b want 00", s_done); end
    n_cmp++; if (s_rdata !== 32'h0000_2810) begin n_err++; $display("FAIL sr_rdata_hold: got %h want 00002810", s_rdata); end
    step();
    n_cmp++; if (c_read !== 1'b0) begin n_err++; $display("FAIL sr_no_regrant: got %b want 0", c_read); end
  endtask

  // Both ports request continuously; last grant was port 0 -> 1,0,1,0.
  task automatic test_round_robin();
    logic exp_p;
    int   w;
    exp_p        = 1'b1;
    s_addr[9:0]  = 10'h010;
    s_addr[19:10] = 10'h020;
    s_read       = 2'b11;
    for (int k = 0; k < 4; k++) begin
      w = 0;
      while (c_read !== 1'b1 && w < 10) begin
        step();
        w++;
      end
      n_cmp++; if (c_read !== 1'b1) begin n_err++; $display("FAIL rr_grant_%0d: got %b want 1 within 10 cycles", k, c_read); end
      if (k > 0) begin
        n_cmp++; if (w !== 2) begin n_err++; $display("FAIL rr_turnaround_%0d: got %0d want 2 cycles", k, w); end
      end
      n_cmp++; if (c_addr !== (exp_p ? 10'h020 : 10'h010)) begin n_err++; $display("FAIL rr_addr_%0d: got %h want %h", k, c_addr, exp_p ? 10'h020 : 10'h010); end
      c_done  = 1'b1;
      c_rdata = 32'hC0DE_0000 + 32'(k);
      step();
      c_done  = 1'b0;
      n_cmp++; if (s_done !== (exp_p ? 2'b10 : 2'b01)) begin n_err++; $display("FAIL rr_done_%0d: got %b want %b", k, s_done, exp_p ? 2'b10 : 2'b01); end
      n_cmp++; if (s_rdata !== 32'hC0DE_0000 + 32'(k)) begin n_err++; $display("FAIL rr_rdata_%0d: got %h want %h", k, s_rdata, 32'hC0DE_0000 + 32'(k)); end
      exp_p = ~exp_p;
    end
    s_read = 2'b00;
    step();
    step();
    n_cmp++; if (c_read !== 1'b0) begin n_err++; $display("FAIL rr_quiet: got %b want 0", c_read); end
  endtask

  // Port 1 write; inputs change mid-transaction but the core side must not.
  task automatic test_write();
    s_addr[19:10]  = 10'h3FF;
    s_fn[15:8]     = 8'h04;
    s_wdata[63:32] = 32'hDEAD_BEEF;
    s_be[7:4]      = 4'b0011;
    s_write[1]     = 1'b1;
    step();
    n_cmp++; if ({c_write, c_read} !== 2'b10) begin n_err++; $display("FAIL wr_dir: got w%b r%b want w1 r0", c_write, c_read); end
    n_cmp++; if ({c_addr, c_fn, c_wdata, c_be} !== {10'h3FF, 8'h04, 32'hDEAD_BEEF, 4'b0011}) begin n_err++; $display("FAIL wr_fields: got a%h f%h d%h be%b want a3ff f04 ddeadbeef be0011", c_addr, c_fn, c_wdata, c_be); end
    s_addr[19:10]  = 10'h000;
    s_fn[15:8]     = 8'hFF;
    s_wdata[63:32] = 32'h0;
    s_be[7:4]      = 4'b1111;
    for (int c = 0; c < 3; c++) begin
      step();
      n_cmp++; if ({c_write, c_addr, c_fn, c_wdata, c_be} !== {1'b1, 10'h3FF, 8'h04, 32'hDEAD_BEEF, 4'b0011}) begin n_err++; $display("FAIL wr_hold_%0d: got w%b a%h f%h d%h be%b", c, c_write, c_addr, c_fn, c_wdata, c_be); end
    end
    c_done  = 1'b1;
    c_rdata = 32'h1234_5678;
    step();
    c_done  = 1'b0;
    n_cmp++; if (c_write !== 1'b0) begin n_err++; $display("FAIL wr_drop: got %b want 0", c_write); end
    n_cmp++; if (s_done !== 2'b10) begin n_err++; $display("FAIL wr_done: got %b want 10", s_done); end
    n_cmp++; if (s_rdata !== 32'h1234_5678) begin n_err++; $display("FAIL wr_rdata: got %h want 12345678", s_rdata); end
    s_write[1] = 1'b0;
    step();
  endtask

  // Read+write together forwards the write; dropping the request does not
  // abort; a done while IDLE is ignored.
  task automatic test_rw_both();
    s_addr[9:0]   = 10'h155;
    s_wdata[31:0] = 32'h0BAD_F00D;
    s_be[3:0]     = 4'b1100;
    s_read[0]     = 1'b1;
    s_write[0]    = 1'b1;
    step();
    n_cmp++; if ({c_write, c_read} !== 2'b10) begin n_err++; $display("FAIL rw_write_only: got w%b r%b want w1 r0", c_write, c_read); end
    n_cmp++; if ({c_addr, c_wdata, c_be} !== {10'h155, 32'h0BAD_F00D, 4'b1100}) begin n_err++; $display("FAIL rw_fields: got a%h d%h be%b", c_addr, c_wdata, c_be); end
    s_read[0]  = 1'b0;
    s_write[0] = 1'b0;
    step();
    step();
    n_cmp++; if ({c_write, s_done} !== 3'b100) begin n_err++; $display("FAIL rw_no_abort: got w%b done%b want w1 done00", c_write, s_done); end
    c_done  = 1'b1;
    c_rdata = 32'h55AA_55AA;
    step();
    c_done  = 1'b0;
    n_cmp++; if ({c_write, s_done} !== 3'b001) begin n_err++; $display("FAIL rw_done: got w%b done%b want w0 done01", c_write, s_done); end
    step();
    c_done  = 1'b1;
    c_rdata = 32'hFFFF_0000;
    step();
    c_done  = 1'b0;
    n_cmp++; if ({s_done, c_read, c_write} !== 4'b0000) begin n_err++; $display("FAIL idle_done_ignored: got %b want 0000", {s_done, c_read, c_write}); end
    n_cmp++; if (s_rdata !== 32'h55AA_55AA) begin n_err++; $display("FAIL idle_rdata_hold: got %h want 55aa55aa", s_rdata); end
  endtask

  // Reset while port 1 is ACTIVE; a late core done produces nothing and
  // priority restarts at port 0.
  task automatic test_reset_mid();
    s_addr[19:10] = 10'h0AA;
    s_read[1]     = 1'b1;
    step();
    n_cmp++; if ({c_read, c_addr} !== {1'b1, 10'h0AA}) begin n_err++; $display("FAIL rm_pre: got r%b a%h want r1 a0aa", c_read, c_addr); end
    step();
    rst = 1'b1;
    step();
    rst       = 1'b0;
    s_read[1] = 1'b0;
    n_cmp++; if ({c_addr, c_fn, c_write, c_wdata, c_be, c_read, s_rdata, s_done, terr} !== '0) begin n_err++; $display("FAIL rm_outputs: got r%b a%h d%h rd%h done%b", c_read, c_addr, c_wdata, s_rdata, s_done); end
    c_done  = 1'b1;
    c_rdata = 32'h0000_0077;
    step();
    c_done  = 1'b0;
    n_cmp++; if ({s_done, s_rdata} !== '0) begin n_err++; $display("FAIL rm_late_done: got done%b rd%h want 0", s_done, s_rdata); end
    s_addr[9:0]   = 10'h101;
    s_addr[19:10] = 10'h202;
    s_read        = 2'b11;
    step();
    n_cmp++; if ({c_read, c_addr} !== {1'b1, 10'h101}) begin n_err++; $display("FAIL rm_port0_first: got r%b a%h want r1 a101", c_read, c_addr); end
    c_done = 1'b1;
    step();
    c_done = 1'b0;
    s_read = 2'b00;
    n_cmp++; if (s_done !== 2'b01) begin n_err++; $display("FAIL rm_done: got %b want 01", s_done); end
    step();
  endtask

`ifdef PCIE_CFG_MGMT_TIMEOUT_EN
  // TIMEOUT=15: 16 active cycles, then abort with all-ones data.
  task automatic test_timeout();
    s_addr[19:10] = 10'h3C0;
    s_read[1]     = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      n_cmp++; if ({c_read, terr, s_done} !== 4'b1000) begin n_err++; $display("FAIL to_active_c%0d: got r%b err%b done%b want r1 err0 done00", c, c_read, terr, s_done); end
    end
    step();
    s_read[1] = 1'b0;
    n_cmp++; if ({c_read, terr, s_done} !== 4'b0110) begin n_err++; $display("FAIL to_abort: got r%b err%b done%b want r0 err1 done10", c_read, terr, s_done); end
    n_cmp++; if (s_rdata !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL to_rdata: got %h want ffffffff", s_rdata); end
    step();
    n_cmp++; if ({terr, s_done} !== 3'b000) begin n_err++; $display("FAIL to_pulse: got err%b done%b want 0", terr, s_done); end
  endtask

  task automatic test_timeout_coincide();
    s_addr[9:0] = 10'h00C;
    s_read[0]   = 1'b1;
    for (int c = 1; c <= 16; c++) begin
      step();
      n_cmp++; if ({c_read, terr} !== 2'b10) begin n_err++; $display("FAIL tc_active_c%0d: got r%b err%b want r1 err0", c, c_read, terr); end
      if (c == 16) begin
        c_done  = 1'b1;
        c_rdata = 32'hA5A5_0001;
      end
    end
    step();
    c_done    = 1'b0;
    s_read[0] = 1'b0;
    n_cmp++; if ({c_read, terr, s_done} !== 4'b0001) begin n_err++; $display("FAIL tc_done: got r%b err%b done%b want r0 err0 done01", c_read, terr, s_done); end
    n_cmp++; if (s_rdata !== 32'hA5A5_0001) begin n_err++; $display("FAIL tc_rdata: got %h want a5a50001", s_rdata); end
    step();
  endtask
`else
  // Without the timeout feature the arbiter waits indefinitely.
  task automatic test_no_timeout();
    s_addr[19:10] = 10'h3C0;
    s_read[1]     = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      n_cmp++; if ({c_read, terr, s_done} !== 4'b1000) begin n_err++; $display("FAIL nt_wait_c%0d: got r%b err%b done%b want r1 err0 done00", c, c_read, terr, s_done); end
    end
    c_done  = 1'b1;
    c_rdata = 32'h0000_4242;
    step();
    c_done    = 1'b0;
    s_read[1] = 1'b0;
    n_cmp++; if ({s_done, s_rdata} !== {2'b10, 32'h0000_4242}) begin n_err++; $display("FAIL nt_done: got done%b rd%h want done10 rd00004242", s_done, s_rdata); end
    step();
  endtask
`endif

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst     = 1'b1;
    s_addr  = '0;
    s_fn    = '0;
    s_write = '0;
    s_wdata = '0;
    s_be    = '0;
    s_read  = '0;
    c_rdata = '0;
    c_done  = 1'b0;
    test_reset();
    test_single_read();
    test_round_robin();
    test_write();
    test_rw_both();
    test_reset_mid();
`ifdef PCIE_CFG_MGMT_TIMEOUT_EN
    test_timeout();
    test_timeout_coincide();
`else
    test_no_timeout();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pcie_us_cfg_mgmt_arb.md
Name: pcie_us_cfg_mgmt_arb

Overview:
- Arbitrates N independent requesters onto the single UltraScale PCIe IP core cfg_mgmt port.
- Example requesters: the configuration shim polling Device Control, a host-visible config-access register block, an MSI-X setup engine.
- Sits directly downstream of those requesters and directly upstream of the IP core.
- Round-robin arbitration, grant held for one complete read/write transaction, per-port completion routing with a registered response.

Parameters:
- PORTS, 2, number of requester ports (1..16).
- TIMEOUT, 1023, cycles to wait for cfg_mgmt_read_write_done before aborting (used only with the optional feature).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- s_cfg_mgmt_addr  in  PORTS*10  per-port dword address; port i at [i*10 +: 10]
- s_cfg_mgmt_function_number  in  PORTS*8  per-port function number
- s_cfg_mgmt_write  in  PORTS  per-port write request, level, held until done
- s_cfg_mgmt_write_data  in  PORTS*32  per-port write data
- s_cfg_mgmt_byte_enable  in  PORTS*4  per-port byte enables
- s_cfg_mgmt_read  in  PORTS  per-port read request, level, held until done
- s_cfg_mgmt_read_data  out  32  read data, shared by all ports; valid with the done pulse
- s_cfg_mgmt_read_write_done  out  PORTS  one-cycle completion pulse to the granted port
- cfg_mgmt_addr  out  10  to IP core
- cfg_mgmt_function_number  out  8  to IP core
- cfg_mgmt_write  out  1  to IP core
- cfg_mgmt_write_data  out  32  to IP core
- cfg_mgmt_byte_enable  out  4  to IP core
- cfg_mgmt_read  out  1  to IP core
- cfg_mgmt_read_data  in  32  from IP core
- cfg_mgmt_read_write_done  in  1  from IP core
- timeout_error  out  1  one-cycle pulse on an aborted transaction

Behaviour:
- Clocking and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - State IDLE.
  - All cfg_mgmt_* outputs 0.
  - s_cfg_mgmt_read_data 0.
  - s_cfg_mgmt_read_write_done 0.
  - timeout_error 0.
  - Round-robin pointer set so port 0 has highest priority.
- A port requests when s_cfg_mgmt_read[i] | s_cfg_mgmt_write[i].
- If a port asserts read and write together, only the write is forwarded (illegal input, defined result).
- State IDLE:
  - If any port requests, grant the first requesting port at or after (last_grant+1) mod PORTS.
  - Register that port's addr, function_number, write_data, byte_enable and read/write onto the cfg_mgmt_* outputs.
  - Move to ACTIVE.
  - Latency: request seen in cycle n gives cfg_mgmt_read/write high in cycle n+1.
- State ACTIVE:
  - cfg_mgmt_* outputs are held constant. Changes on the granted port's inputs are ignored.
  - On cfg_mgmt_read_write_done (cycle m):
    - cycle m+1: cfg_mgmt_read/write = 0;
    - cycle m+1: s_cfg_mgmt_read_data = captured cfg_mgmt_read_data (also captured for writes);
    - cycle m+1: s_cfg_mgmt_read_write_done[grant] = 1;
    - update last_grant; move to DONE.
- State DONE: one turnaround cycle with no arbitration.
  - Lets the requester drop its registered request after seeing done, so it is not re-granted spuriously.
  - done returns to 0; move to IDLE.
- Throughput: at most one transaction every (IP latency + 3) cycles.
- A done input in IDLE or DONE is ignored.
- A request deasserted while ACTIVE does not abort; the transaction completes and done is still pulsed.
- PORTS=1: the arbiter degenerates to a registered pass-through with the same timing.
- Reset mid-transaction: all outputs return to reset values next cycle; the outstanding IP core transaction is abandoned and no done is generated.
- s_cfg_mgmt_read_data holds its value until the next completion.

Optional Feature:
- Macro: PCIE_CFG_MGMT_TIMEOUT_EN.
- Defined:
  - A counter loads TIMEOUT on entry to ACTIVE and decrements each cycle without done.
  - At 0 without done:
    - cfg_mgmt_read/write = 0 next cycle;
    - s_cfg_mgmt_read_data = 32'hFFFFFFFF;
    - done pulsed to the granted port;
    - timeout_error pulsed one cycle;
    - go to DONE.
  - If done and expiry coincide, the done wins (normal completion, no error).
- Undefined: ACTIVE waits indefinitely; timeout_error is tied 0; no counter is instantiated.

Test Plan:
- PORTS=2, port 0 reads addr 0x032 fn 0, core returns done after 5 cycles with data 0x00002810 -> cfg_mgmt_read high cycle 1..6, s_done[0] pulse cycle 7 with read_data 0x00002810, s_done[1] stays 0.
- Both ports request reads continuously -> grants alternate 0,1,0,1; each done pulse goes only to its own port; no back-to-back grant to the same port.
- Port 1 writes 0xDEADBEEF, byte_enable 4'b0011 to addr 0x3FF fn 8'h04 -> IP sees exactly those values, held stable until done; cfg_mgmt_write drops the cycle after done.
- rst asserted while ACTIVE -> next cycle all outputs 0; a late cfg_mgmt_read_write_done produces no s_done; next request granted to port 0.
- With PCIE_CFG_MGMT_TIMEOUT_EN, TIMEOUT=15, core never responds -> cfg_mgmt_read drops after 16 active cycles; s_done pulse with read_data 0xFFFFFFFF; timeout_error one-cycle pulse.
- With PCIE_CFG_MGMT_TIMEOUT_EN, done arrives on the expiry cycle -> normal completion, captured data returned, timeout_error stays 0.
